// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - arbiter state, requester id and ALU flag types
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef logic id_t;

    // Bit order matches the resp_flags port: {z, n, c, sn}
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic sn;
    } flags_t;

endpackage

// File: rtl/alu_instr_pkg.sv
// rtl/alu_instr_pkg.sv - opcodes, instruction format and result width shared by ALU users
package alu_instr_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2,
        OP_MUL = 2'd3
    } opcode_t;

    typedef logic [7:0]  word_t;
    typedef logic [15:0] long_t;

    typedef struct packed {
        opcode_t op;
        word_t   arg0;
        word_t   arg1;
    } instruction_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational 8-bit ALU with carry-in on ADD and 16-bit MUL product
module alu_arbiter_alu
    import alu_instr_pkg::*;
    import alu_arbiter_pkg::*;
(
    input  opcode_t    op,
    input  word_t      a,
    input  word_t      b,
    input  logic       cin,
    output long_t      result,
    output flags_t     flags
);

    logic [8:0]  sum9;
    logic [15:0] prod;
    logic        ovf;

    // SUB carry is the ARM-style "no borrow" bit; only ADD consumes carry-in
    always_comb begin
        sum9   = '0;
        prod   = '0;
        ovf    = 1'b0;
        result = '0;
        flags  = '0;
        case (op)
            OP_ADD: begin
                sum9     = {1'b0, a} + {1'b0, b} + {8'b0, cin};
                ovf      = (a[7] == b[7]) && (sum9[7] != a[7]);
                result   = {8'h00, sum9[7:0]};
                flags.z  = (sum9[7:0] == 8'h00);
                flags.n  = sum9[7];
                flags.c  = sum9[8];
                flags.sn = sum9[7] ^ ovf;
            end
            OP_SUB: begin
                sum9     = {1'b0, a} + {1'b0, ~b} + 9'd1;
                ovf      = (a[7] != b[7]) && (sum9[7] != a[7]);
                result   = {8'h00, sum9[7:0]};
                flags.z  = (sum9[7:0] == 8'h00);
                flags.n  = sum9[7];
                flags.c  = sum9[8];
                flags.sn = sum9[7] ^ ovf;
            end
            OP_MUL: begin
                prod     = 16'(a) * 16'(b);
                result   = prod;
                flags.z  = (prod == 16'h0000);
                flags.n  = prod[15];
                flags.c  = |prod[15:8];
                flags.sn = 1'b0;
            end
            default: begin
                result = '0;
                flags  = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared multi-cycle ALU
module alu_arbiter
    import alu_instr_pkg::*;
    import alu_arbiter_pkg::*;
#(
    parameter int MUL_LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  instruction_t req_instr0,
    input  instruction_t req_instr1,
    output logic         resp_valid,
    input  logic         resp_ready,
    output id_t          resp_id,
    output long_t        resp_result,
    output logic [3:0]   resp_flags,
    output logic         busy
);

    state_t       state, state_nx;
    instruction_t instr_q, sel_instr;
    id_t          id_q, last_grant, grant;
    logic [3:0]   cnt_q;
    logic [1:0]   carry_q;
    flags_t       flags_q, alu_flags;
    long_t        alu_result;
    logic         offer, accept, exec_done;

    alu_arbiter_alu u_alu (
        .op     (instr_q.op),
        .a      (instr_q.arg0),
        .b      (instr_q.arg1),
        .cin    (carry_q[id_q]),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_comb begin
        state_nx  = state;
        req_ready = 2'b00;
        // Contention goes to whoever did not win last; a lone requester always wins
        grant     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        sel_instr = grant ? req_instr1 : req_instr0;
        offer     = !reset && (state == S_IDLE || (state == S_RESP && resp_ready));
        if (offer && (req_valid != 2'b00))
            req_ready = grant ? 2'b10 : 2'b01;
        accept    = (req_ready != 2'b00);
        exec_done = (state == S_EXEC) && (cnt_q == 4'd1);
        case (state)
            S_IDLE: if (accept) state_nx = S_EXEC;
            S_EXEC: if (exec_done) state_nx = S_RESP;
            S_RESP: if (resp_ready) state_nx = accept ? S_EXEC : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            instr_q     <= '0;
            id_q        <= 1'b0;
            last_grant  <= 1'b1;
            cnt_q       <= 4'd0;
            carry_q     <= 2'b00;
            resp_id     <= 1'b0;
            resp_result <= '0;
            flags_q     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                instr_q    <= sel_instr;
                id_q       <= grant;
                last_grant <= grant;
                cnt_q      <= (sel_instr.op == OP_MUL) ? 4'(MUL_LATENCY) : 4'd1;
            end else if (state == S_EXEC) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (exec_done) begin
                resp_id     <= id_q;
                resp_result <= alu_result;
                flags_q     <= alu_flags;
                if (instr_q.op != OP_NOP)
                    carry_q[id_q] <= alu_flags.c;
            end
        end
    end

    assign resp_valid = (state == S_RESP);
    assign resp_flags = flags_q;
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
    import alu_instr_pkg::*;
    import alu_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    instruction_t req_instr0, req_instr1;
    logic         resp_valid, resp_ready;
    id_t          resp_id;
    long_t        resp_result;
    logic [3:0]   resp_flags;
    logic         busy;

    int passed = 0;
    int total  = 0;

    alu_arbiter #(.MUL_LATENCY(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_instr0  (req_instr0),
        .req_instr1  (req_instr1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_flags  (resp_flags),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic instruction_t mk(input opcode_t op, input logic [7:0] a, input logic [7:0] b);
        instruction_t i;
        i.op   = op;
        i.arg0 = a;
        i.arg1 = b;
        return i;
    endfunction

    // Called at a negedge in IDLE with resp_ready high; returns at the negedge after RESP
    task automatic run1(input string tag, input bit rid, input instruction_t ins,
                        input logic [31:0] er, input logic [31:0] ef);
        int n;
        if (rid) req_instr1 = ins; else req_instr0 = ins;
        req_valid = rid ? 2'b10 : 2'b01;
        #1 chk({tag, "_ready"}, 32'(req_ready), rid ? 2 : 1);
        @(negedge clk);
        req_valid = 2'b00;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(resp_valid), 1);
        chk({tag, "_id"}, 32'(resp_id), 32'(rid));
        chk({tag, "_result"}, 32'(resp_result), er);
        chk({tag, "_flags"}, 32'(resp_flags), ef);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int busy_cnt, seen, seen_at, spurious;
    logic [31:0] exp_id, exp_rdy;

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        req_instr0 = '0;
        req_instr1 = '0;

        // Reset values, ready held off even with both requesters valid
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        chk("rst_ready",  32'(req_ready),   0);
        chk("rst_valid",  32'(resp_valid),  0);
        chk("rst_id",     32'(resp_id),     0);
        chk("rst_result", 32'(resp_result), 0);
        chk("rst_flags",  32'(resp_flags),  0);
        chk("rst_busy",   32'(busy),        0);

        // Single ADD with exact timing
        @(negedge clk);
        reset      = 1'b0;
        req_instr0 = mk(OP_ADD, 8'h01, 8'h02);
        req_valid  = 2'b01;
        #1 chk("add_ready", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 2'b00;
        chk("add_exec_busy",  32'(busy),       1);
        chk("add_exec_valid", 32'(resp_valid), 0);
        @(negedge clk);
        chk("add_valid",  32'(resp_valid),  1);
        chk("add_id",     32'(resp_id),     0);
        chk("add_result", 32'(resp_result), 'h3);
        chk("add_flags",  32'(resp_flags),  'h0);
        @(negedge clk);
        chk("add_idle_busy",  32'(busy),       0);
        chk("add_idle_valid", 32'(resp_valid), 0);

        // Contention: grants 0,1,0 with same-cycle re-accept in RESP
        do_reset();
        req_instr0 = mk(OP_SUB, 8'h01, 8'h02);
        req_instr1 = mk(OP_SUB, 8'h01, 8'h02);
        req_valid  = 2'b11;
        #1 chk("cont_ready0", 32'(req_ready), 1);
        for (int k = 0; k < 3; k++) begin
            exp_id  = (k == 1) ? 1 : 0;
            exp_rdy = (k == 1) ? 1 : 2;
            @(negedge clk);
            chk("cont_exec_valid", 32'(resp_valid), 0);
            chk("cont_exec_ready", 32'(req_ready),  0);
            @(negedge clk);
            chk("cont_valid",  32'(resp_valid),  1);
            chk("cont_id",     32'(resp_id),     exp_id);
            chk("cont_result", 32'(resp_result), 'hff);
            chk("cont_flags",  32'(resp_flags),  'h5);
            if (k < 2) chk("cont_ready", 32'(req_ready), exp_rdy);
            else req_valid = 2'b00;
        end
        @(negedge clk);
        chk("cont_idle_busy", 32'(busy), 0);

        // Per-requester carry, NOP leaves it untouched
        run1("addc",   1'b0, mk(OP_ADD, 8'hff, 8'h01), 'h0, 'ha);
        run1("nop",    1'b0, mk(OP_NOP, 8'h12, 8'h34), 'h0, 'h0);
        run1("add_ci", 1'b0, mk(OP_ADD, 8'h01, 8'h02), 'h4, 'h0);
        run1("add_r1", 1'b1, mk(OP_ADD, 8'h01, 8'h02), 'h3, 'h0);

        // MUL with latency 3 from requester 1
        req_instr1 = mk(OP_MUL, 8'h03, 8'h02);
        req_valid  = 2'b10;
        @(negedge clk);
        req_valid = 2'b00;
        busy_cnt = 0; seen = 0; seen_at = -1;
        for (int c = 0; c < 6; c++) begin
            if (busy) busy_cnt++;
            if (resp_valid) begin
                seen++;
                seen_at = c;
                chk("mul_result", 32'(resp_result), 'h6);
                chk("mul_id",     32'(resp_id),     1);
            end
            @(negedge clk);
        end
        chk("mul_busy_cycles", busy_cnt, 4);
        chk("mul_seen",        seen,     1);
        chk("mul_latency",     seen_at,  3);

        // Backpressure, then same-cycle accept when resp_ready rises
        resp_ready = 1'b0;
        req_instr1 = mk(OP_ADD, 8'h05, 8'h06);
        req_valid  = 2'b10;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        req_instr0 = mk(OP_ADD, 8'h01, 8'h01);
        req_valid  = 2'b01;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_valid",  32'(resp_valid),  1);
            chk("bp_result", 32'(resp_result), 'hb);
            chk("bp_id",     32'(resp_id),     1);
            chk("bp_ready",  32'(req_ready),   0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_acc_ready", 32'(req_ready),  1);
        chk("bp_acc_valid", 32'(resp_valid), 1);
        @(negedge clk);
        req_valid = 2'b00;
        chk("bp_exec_busy",  32'(busy),        1);
        chk("bp_exec_valid", 32'(resp_valid),  0);
        chk("bp_exec_hold",  32'(resp_result), 'hb);
        @(negedge clk);
        chk("bp2_valid",  32'(resp_valid),  1);
        chk("bp2_id",     32'(resp_id),     0);
        chk("bp2_result", 32'(resp_result), 'h2);
        @(negedge clk);

        // Reset during a MUL in EXEC: no response, carry cleared
        run1("pre0", 1'b0, mk(OP_ADD, 8'hff, 8'h01), 'h0, 'ha);
        run1("pre1", 1'b1, mk(OP_ADD, 8'hff, 8'h01), 'h0, 'ha);
        req_instr0 = mk(OP_MUL, 8'h03, 8'h02);
        req_valid  = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        chk("mr_exec_busy", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_busy",   32'(busy),        0);
        chk("mr_valid",  32'(resp_valid),  0);
        chk("mr_result", 32'(resp_result), 0);
        reset = 1'b0;
        spurious = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid) spurious++;
        end
        chk("mr_no_resp", spurious, 0);
        run1("post0", 1'b0, mk(OP_ADD, 8'h01, 8'h02), 'h3, 'h0);
        run1("post1", 1'b1, mk(OP_ADD, 8'h01, 8'h02), 'h3, 'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 2, meaning EXEC cycles spent on a MUL; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 2 bits, per-requester request valid (bit 0 = requester 0).
REQ-005 SHALL have port req_ready, output, 2 bits, per-requester accept; at most one bit set in any cycle.
REQ-006 SHALL have ports req_instr0 and req_instr1, input, instruction_t each, the instruction offered by each requester.
REQ-007 SHALL have port resp_valid, output, 1 bit, response holding.
REQ-008 SHALL have port resp_ready, input, 1 bit, consumer accepts response.
REQ-009 SHALL have port resp_id, output, 1 bit, requester that owns the response.
REQ-010 SHALL have port resp_result, output, long_t, captured ALU result.
REQ-011 SHALL have port resp_flags, output, 4 bits, captured {z, n, c, sn}.
REQ-012 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, EXEC and RESP.
REQ-014 Accept: occurs when req_valid[i] and req_ready[i] are both high in the same cycle.
REQ-015 Ready rule: req_ready is offered only in IDLE, or in RESP in the same cycle resp_ready is high.
REQ-016 Arbitration: one valid requester wins; if both are valid, the winner is the requester other than last_grant (round-robin); last_grant updates on every accept.
REQ-017 On accept: latch instruction and id; load cycle counter with MUL_LATENCY for MUL, otherwise 1; go to EXEC.
REQ-018 EXEC: drive the shared ALU from the latched instruction, with carry input carry_q[id]; decrement the counter each cycle.
REQ-019 EXEC exit: in the cycle the counter equals 1, capture result and flags into the resp registers and go to RESP.
REQ-020 Latency: non-MUL responses appear 2 cycles after the accept edge; MUL responses appear MUL_LATENCY+1 cycles after it.
REQ-021 RESP: resp_valid is high and resp_id/result/flags stay stable until resp_ready is high.
REQ-022 RESP exit: on resp_ready, go to EXEC if a same-cycle accept occurs, else to IDLE.
REQ-023 carry_q: hold a 2-entry per-requester carry; carry_q[id] takes the ALU c output at EXEC exit for ADD, SUB and MUL only; NOP leaves it unchanged.
REQ-024 NOP: still traverses EXEC and RESP, returning the ALU NOP output (result 0, flags 0).
REQ-025 Input stability: requests not accepted are ignored; requesters hold their instruction until accepted.
REQ-026 Bus idle values: in IDLE and EXEC, resp_valid is 0 and resp data holds its last captured value.

Reset
REQ-027 On reset: state IDLE; resp_valid 0; resp_id 0; resp_result 0; resp_flags 0; busy 0; req_ready 0 during the reset cycle; carry_q 0; last_grant 1, so requester 0 wins first.
REQ-028 Reset mid-operation: reset in EXEC or RESP discards the in-flight operation with no response and no carry_q update; it takes priority over all other events.

Structure
REQ-029 The state enum, requester-id type and the 4-bit flag struct SHALL live in the shared types package; opcode values come from the instructions package.
REQ-030 The design SHALL instantiate exactly one sub-module, the existing ALU; arbitration, counter and response registers are local logic.

Verification
REQ-031 ADD: after reset, req_valid=01 with ADD 8.8 arg0=1, arg1=2 -> accepted next edge; 2 cycles later resp_valid=1, resp_id=0, resp_result=0x3, z=0, n=0, sn=0.
REQ-032 Contention: both requesters valid continuously after reset with SUB 1,2 -> grants alternate 0,1,0; each result is 0xff; req_ready is never 11.
REQ-033 MUL: MUL_LATENCY=3, MUL arg0=3, arg1=2 from requester 1 -> busy for 4 cycles, then resp_result=0x6, resp_id=1.
REQ-034 Backpressure: resp_ready low for 5 cycles in RESP -> outputs stable, req_ready=00; the cycle resp_ready rises with req_valid=01 -> accept in the same cycle and go straight to EXEC.
REQ-035 Reset mid-operation: reset asserted during EXEC of a MUL -> next cycle state IDLE, resp_valid=0, carry_q=00, and no response is ever produced for that MUL.
